// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
package sseg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;

    // Active-low one-zero anode pattern for a digit index.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Signal bundle between the display data source and the scan controller.
interface sseg_scan_ctrl_if;
    logic       en;
    logic       lzb_en;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [3:0] bcd_lat0;
    logic [3:0] bcd_lat1;
    logic [3:0] bcd_lat2;
    logic [3:0] bcd_lat3;
    logic       dp_n;
    logic       frame_start;

    modport master (
        output en, lzb_en, bcd0, bcd1, bcd2, bcd3, dp_in,
        input  an, bcd_lat0, bcd_lat1, bcd_lat2, bcd_lat3, dp_n, frame_start
    );

    modport slave (
        input  en, lzb_en, bcd0, bcd1, bcd2, bcd3, dp_in,
        output an, bcd_lat0, bcd_lat1, bcd_lat2, bcd_lat3, dp_n, frame_start
    );
endinterface

// File: rtl/sseg_scan_ctrl_lzb.sv
// Leading-zero blanking mask: a digit goes dark when it and every digit to
// its left are zero without a decimal point. Digit 0 always stays lit.
module sseg_lzb (
    input  logic [3:0] bcd_lat0,
    input  logic [3:0] bcd_lat1,
    input  logic [3:0] bcd_lat2,
    input  logic [3:0] bcd_lat3,
    input  logic [3:0] dp_lat,
    input  logic       lzb_en,
    output logic [3:0] suppress
);
    always_comb begin
        suppress    = '0;
        suppress[3] = lzb_en && (bcd_lat3 == 4'd0) && !dp_lat[3];
        suppress[2] = suppress[3] && (bcd_lat2 == 4'd0) && !dp_lat[2];
        suppress[1] = suppress[2] && (bcd_lat1 == 4'd0) && !dp_lat[1];
    end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller: per-frame snapshot,
// rotating active-low anode select, dark guard per slot, optional zero blanking.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 25000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned CNT_W        = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    sseg_scan_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [1:0]       IDX_LAST   = 2'(NUM_DIGITS - 1);

    state_t           state, nxt_state;
    logic [1:0]       idx, nxt_idx;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             latch;
    logic [3:0]       lat0, lat1, lat2, lat3, dp_lat;
    logic [3:0]       suppress;
    logic [3:0]       an_q, an_d;
    logic             dp_n_q, dp_n_d, fs_q;

    sseg_lzb u_lzb (
        .bcd_lat0 (lat0),
        .bcd_lat1 (lat1),
        .bcd_lat2 (lat2),
        .bcd_lat3 (lat3),
        .dp_lat   (dp_lat),
        .lzb_en   (bus.lzb_en),
        .suppress (suppress)
    );

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        latch     = 1'b0;
        if (!bus.en) begin
            // Enable loss overrides everything, including a frame wrap.
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                    latch     = 1'b1;
                end
                BLANK: begin
                    nxt_cnt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) nxt_state = SHOW;
                end
                SHOW: begin
                    if (cnt == DIGIT_LAST) begin
                        nxt_state = BLANK;
                        nxt_cnt   = '0;
                        nxt_idx   = idx + 1'b1;
                        latch     = (idx == IDX_LAST);
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        an_d   = AN_OFF;
        dp_n_d = 1'b1;
        if (nxt_state == SHOW && !suppress[nxt_idx]) begin
            an_d   = an_select(nxt_idx);
            dp_n_d = ~dp_lat[nxt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            lat0   <= '0;
            lat1   <= '0;
            lat2   <= '0;
            lat3   <= '0;
            dp_lat <= '0;
            an_q   <= AN_OFF;
            dp_n_q <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            state  <= nxt_state;
            idx    <= nxt_idx;
            cnt    <= nxt_cnt;
            an_q   <= an_d;
            dp_n_q <= dp_n_d;
            fs_q   <= latch;
            if (latch) begin
                lat0   <= bus.bcd0;
                lat1   <= bus.bcd1;
                lat2   <= bus.bcd2;
                lat3   <= bus.bcd3;
                dp_lat <= bus.dp_in;
            end
        end
    end

    assign bus.an          = an_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.frame_start = fs_q;
    assign bus.bcd_lat0    = lat0;
    assign bus.bcd_lat1    = lat1;
    assign bus.bcd_lat2    = lat2;
    assign bus.bcd_lat3    = lat3;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_sseg_scan_ctrl;

    typedef struct packed {
        logic [3:0]  an;
        logic        dpn;
        logic        fs;
        logic [15:0] lat;
    } exp_t;

    // an_s: expected anode per slot during SHOW, slot 3 in [15:12]; dpn_s bit k = dp_n in slot k.
    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        logic [15:0] an_s;
        logic [3:0]  dpn_s;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];
    vec_t tbl[7];

    sseg_scan_ctrl_if bus ();

    sseg_scan_ctrl #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dut_lat();
        return {bus.bcd_lat3, bus.bcd_lat2, bus.bcd_lat1, bus.bcd_lat0};
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_one(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        cmp({tag, " an"},          16'(bus.an),          16'(e.an));
        cmp({tag, " dp_n"},        16'(bus.dp_n),        16'(e.dpn));
        cmp({tag, " frame_start"}, 16'(bus.frame_start), 16'(e.fs));
        cmp({tag, " bcd_lat"},     dut_lat(),            e.lat);
    endtask

    // Called at a negedge: one clock edge, then compare at the next negedge.
    task automatic step(input exp_t e, input string tag);
        exp_q.push_back(e);
        @(negedge clk);
        check_one(tag);
    endtask

    function automatic exp_t frame_exp(input vec_t v, input int t, input logic [15:0] lat);
        exp_t e;
        int   slot;
        int   pos;
        slot  = (t % 32) / 8;
        pos   = t % 8;
        e.fs  = ((t % 32) == 0);
        e.lat = lat;
        e.an  = (pos < 2) ? 4'hF : v.an_s[slot*4 +: 4];
        e.dpn = (pos < 2) ? 1'b1 : v.dpn_s[slot];
        return e;
    endfunction

    function automatic exp_t dark(input logic [15:0] lat);
        exp_t e;
        e.an  = 4'hF;
        e.dpn = 1'b1;
        e.fs  = 1'b0;
        e.lat = lat;
        return e;
    endfunction

    task automatic set_in(input logic [15:0] bcd, input logic [3:0] dp, input logic lzb);
        {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} = bcd;
        bus.dp_in  = dp;
        bus.lzb_en = lzb;
    endtask

    logic [15:0] lat_now;

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        bus.en = 1'b0;
        set_in(v.bcd, v.dp, v.lzb);
        step(dark(lat_now), {tag, " idle"});
        bus.en = 1'b1;
        for (int t = 0; t <= 32; t++)
            step(frame_exp(v, t, v.bcd), $sformatf("%s t%0d", tag, t));
        lat_now = v.bcd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0] = '{bcd:16'h4321, dp:4'b0000, lzb:1'b0, an_s:16'h7BDE, dpn_s:4'b1111};
        tbl[1] = '{bcd:16'h0050, dp:4'b0000, lzb:1'b1, an_s:16'hFFDE, dpn_s:4'b1111};
        tbl[2] = '{bcd:16'h0050, dp:4'b1000, lzb:1'b1, an_s:16'h7BDE, dpn_s:4'b0111};
        tbl[3] = '{bcd:16'h4321, dp:4'b0100, lzb:1'b0, an_s:16'h7BDE, dpn_s:4'b1011};
        tbl[4] = '{bcd:16'h0000, dp:4'b0000, lzb:1'b1, an_s:16'hFFFE, dpn_s:4'b1111};
        tbl[5] = '{bcd:16'hFA00, dp:4'b0000, lzb:1'b1, an_s:16'h7BDE, dpn_s:4'b1111};
        tbl[6] = '{bcd:16'h0700, dp:4'b0001, lzb:1'b1, an_s:16'hFBDE, dpn_s:4'b1110};

        rst_n  = 1'b0;
        bus.en = 1'b0;
        set_in(16'h0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        cmp("reset an",          16'(bus.an),          16'hF);
        cmp("reset dp_n",        16'(bus.dp_n),        16'h1);
        cmp("reset frame_start", 16'(bus.frame_start), 16'h0);
        cmp("reset bcd_lat",     dut_lat(),            16'h0000);
        rst_n   = 1'b1;
        lat_now = 16'h0000;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Mid-frame change of bcd0 must wait for the next snapshot.
        run_vec(tbl[0], 0);
        for (int t = 1; t <= 9; t++) step(frame_exp(tbl[0], t, 16'h4321), $sformatf("hold t%0d", t));
        bus.bcd0 = 4'h9;
        for (int t = 10; t <= 31; t++) step(frame_exp(tbl[0], t, 16'h4321), $sformatf("hold t%0d", t));
        step(frame_exp(tbl[0], 32, 16'h4329), "hold newframe");

        // Enable dropped during digit 1 SHOW, then restarted with fresh data.
        for (int t = 1; t <= 11; t++) step(frame_exp(tbl[0], t, 16'h4329), $sformatf("endrop t%0d", t));
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) step(dark(16'h4329), $sformatf("endrop dark%0d", k));
        set_in(16'h4321, 4'b0000, 1'b0);
        bus.en = 1'b1;
        for (int t = 0; t <= 31; t++) step(frame_exp(tbl[0], t, 16'h4321), $sformatf("restart t%0d", t));

        // Enable falls exactly on the frame wrap: no snapshot, no pulse.
        bus.en   = 1'b0;
        bus.bcd0 = 4'h8;
        step(dark(16'h4321), "wrap_en_fall");
        step(dark(16'h4321), "wrap_en_fall hold");

        // Asynchronous reset in the middle of a SHOW slot.
        set_in(16'h4321, 4'b0000, 1'b0);
        bus.en = 1'b1;
        for (int t = 0; t <= 4; t++) step(frame_exp(tbl[0], t, 16'h4321), $sformatf("prerst t%0d", t));
        #2 rst_n = 1'b0;
        #1;
        cmp("async rst an",          16'(bus.an),          16'hF);
        cmp("async rst dp_n",        16'(bus.dp_n),        16'h1);
        cmp("async rst frame_start", 16'(bus.frame_start), 16'h0);
        cmp("async rst bcd_lat",     dut_lat(),            16'h0000);
        @(negedge clk);
        set_in(16'h1234, 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int t = 0; t <= 9; t++) step(frame_exp(tbl[0], t, 16'h1234), $sformatf("postrst t%0d", t));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
